// File: rtl/calc_line_writer.sv
// rtl/calc_line_writer.sv - calculator screen line writer: fills the text char buffer one line per enter press
module calc_line_writer #(
    parameter int          ROWS       = 4,
    parameter int          COLS       = 9,
    parameter logic [5:0]  SPACE_CODE = 6'o40
) (
    input  logic                    CLOCK_50,
    input  logic                    ar,
    input  logic                    enter,
    input  logic                    clear_req,
    input  logic                    aSign,
    input  logic                    bSign,
    input  logic                    bothSign,
    input  logic [3:0]              x_in1,
    input  logic [3:0]              x_in2,
    input  logic [3:0]              x_in3,
    input  logic [3:0]              x_in4,
    input  logic [3:0]              Op,
    output logic                    wr_en,
    output logic [$clog2(ROWS)-1:0] wr_row,
    output logic [$clog2(COLS)-1:0] wr_col,
    output logic [5:0]              wr_data,
    output logic                    busy,
    output logic                    done,
    output logic [$clog2(ROWS)-1:0] cur_line
);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
    localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);

    typedef enum logic [1:0] {IDLE, CLEAR, WRITE, DONE} state_t;

    state_t     state;
    logic       s1, s2, s3;
    logic       rise;
    logic       pend_enter, pend_clr;
    logic       c_asign, c_bsign, c_both;
    logic [3:0] c_a, c_b, c_rh, c_rl;
    logic [1:0] c_op;
    logic       unused_op;

    assign rise      = s2 & ~s3;
    assign unused_op = ^Op[3:2];

    function automatic logic [5:0] char_of(input logic [CW-1:0] col,
                                           input logic as, input logic bs, input logic rs,
                                           input logic [3:0] a, input logic [3:0] b,
                                           input logic [3:0] rh, input logic [3:0] rl,
                                           input logic [1:0] op);
        logic [5:0] c;
        c = SPACE_CODE;
        case (int'(col))
            0: c = as ? 6'o55 : SPACE_CODE;
            1: c = {2'b11, a};
            2: case (op)
                   2'b00:   c = 6'o55;
                   2'b01:   c = 6'o53;
                   2'b10:   c = 6'o52;
                   default: c = 6'o57;
               endcase
            3: c = bs ? 6'o55 : SPACE_CODE;
            4: c = {2'b11, b};
            5: c = 6'o75;
            6: c = rs ? 6'o55 : SPACE_CODE;
            7: c = {2'b11, rh};
            8: c = {2'b11, rl};
            default: c = SPACE_CODE;
        endcase
        return c;
    endfunction

    always_ff @(posedge CLOCK_50 or negedge ar) begin
        if (!ar) begin
            state      <= CLEAR;
            s1         <= 1'b0;
            s2         <= 1'b0;
            s3         <= 1'b0;
            pend_enter <= 1'b0;
            pend_clr   <= 1'b0;
            c_asign    <= 1'b0;
            c_bsign    <= 1'b0;
            c_both     <= 1'b0;
            c_a        <= '0;
            c_b        <= '0;
            c_rh       <= '0;
            c_rl       <= '0;
            c_op       <= '0;
            wr_en      <= 1'b0;
            wr_row     <= '0;
            wr_col     <= '0;
            wr_data    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            cur_line   <= '0;
        end else begin
            s1   <= enter;
            s2   <= s1;
            s3   <= s2;
            done <= 1'b0;
            // Requests arriving while busy are held (one deep) until IDLE.
            if (state != IDLE) begin
                if (rise)      pend_enter <= 1'b1;
                if (clear_req) pend_clr   <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (clear_req || pend_clr) begin
                        state      <= CLEAR;
                        busy       <= 1'b1;
                        pend_clr   <= 1'b0;
                        pend_enter <= 1'b0;
                        wr_en      <= 1'b1;
                        wr_row     <= '0;
                        wr_col     <= '0;
                        wr_data    <= SPACE_CODE;
                    end else if (rise || pend_enter) begin
                        state      <= WRITE;
                        busy       <= 1'b1;
                        pend_enter <= 1'b0;
                        c_asign    <= aSign;
                        c_bsign    <= bSign;
                        c_both     <= bothSign;
                        c_a        <= x_in4;
                        c_b        <= x_in1;
                        c_rh       <= x_in2;
                        c_rl       <= x_in3;
                        c_op       <= Op[1:0];
                        wr_en      <= 1'b1;
                        wr_row     <= cur_line;
                        wr_col     <= '0;
                        wr_data    <= char_of('0, aSign, bSign, bothSign,
                                              x_in4, x_in1, x_in2, x_in3, Op[1:0]);
                    end
                end
                CLEAR: begin
                    busy <= 1'b1;
                    // wr_en low here only on the first cycle after reset: start the sweep.
                    if (!wr_en) begin
                        wr_en   <= 1'b1;
                        wr_row  <= '0;
                        wr_col  <= '0;
                        wr_data <= SPACE_CODE;
                    end else if (wr_col == LAST_COL) begin
                        wr_col <= '0;
                        if (wr_row == LAST_ROW) begin
                            state    <= IDLE;
                            busy     <= 1'b0;
                            wr_en    <= 1'b0;
                            wr_row   <= '0;
                            wr_data  <= '0;
                            cur_line <= '0;
                        end else begin
                            wr_row <= wr_row + 1'b1;
                        end
                    end else begin
                        wr_col <= wr_col + 1'b1;
                    end
                end
                WRITE: begin
                    if (wr_col == LAST_COL) begin
                        state   <= DONE;
                        done    <= 1'b1;
                        wr_en   <= 1'b0;
                        wr_row  <= '0;
                        wr_col  <= '0;
                        wr_data <= '0;
                    end else begin
                        wr_col  <= wr_col + 1'b1;
                        wr_data <= char_of(wr_col + 1'b1, c_asign, c_bsign, c_both,
                                           c_a, c_b, c_rh, c_rl, c_op);
                    end
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    cur_line <= cur_line + 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_calc_line_writer.sv
// tb/tb_calc_line_writer.sv - directed scoreboard bench for calc_line_writer
module tb_calc_line_writer;
    logic       CLOCK_50 = 1'b0;
    logic       ar = 1'b0;
    logic       enter = 1'b0;
    logic       clear_req = 1'b0;
    logic       aSign = 1'b0, bSign = 1'b0, bothSign = 1'b0;
    logic [3:0] x_in1 = '0, x_in2 = '0, x_in3 = '0, x_in4 = '0, Op = '0;
    logic       wr_en, busy, done;
    logic [1:0] wr_row, cur_line;
    logic [3:0] wr_col;
    logic [5:0] wr_data;

    typedef struct packed {
        logic [1:0] row;
        logic [3:0] col;
        logic [5:0] data;
    } wr_t;

    wr_t q[$];
    wr_t got, exp_w;
    int  compared = 0;
    int  mismatched = 0;
    int  done_cnt = 0;
    int  done_exp = 0;

    calc_line_writer dut (
        .CLOCK_50(CLOCK_50), .ar(ar), .enter(enter), .clear_req(clear_req),
        .aSign(aSign), .bSign(bSign), .bothSign(bothSign),
        .x_in1(x_in1), .x_in2(x_in2), .x_in3(x_in3), .x_in4(x_in4), .Op(Op),
        .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
        .busy(busy), .done(done), .cur_line(cur_line)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Every buffer write must match the head of the scoreboard.
    always @(negedge CLOCK_50) begin
        if (done) done_cnt++;
        if (wr_en) begin
            got = '{row: wr_row, col: wr_col, data: wr_data};
            compared++;
            assert (q.size() > 0) else begin
                mismatched++;
                $error("FAIL unexpected_write observed row=%0d col=%0d data=%o expected none",
                       wr_row, wr_col, wr_data);
            end
            if (q.size() > 0) begin
                exp_w = q.pop_front();
                compared++;
                assert (got === exp_w) else begin
                    mismatched++;
                    $error("FAIL write observed row=%0d col=%0d data=%o expected row=%0d col=%0d data=%o",
                           got.row, got.col, got.data, exp_w.row, exp_w.col, exp_w.data);
                end
            end
        end
    end

    function automatic logic [5:0] model_char(int col);
        logic [5:0] sp;
        logic [5:0] ops[4];
        sp  = 6'o40;
        ops = '{6'o55, 6'o53, 6'o52, 6'o57};
        case (col)
            0: return aSign ? 6'o55 : sp;
            1: return {2'b11, x_in4};
            2: return ops[Op[1:0]];
            3: return bSign ? 6'o55 : sp;
            4: return {2'b11, x_in1};
            5: return 6'o75;
            6: return bothSign ? 6'o55 : sp;
            7: return {2'b11, x_in2};
            default: return {2'b11, x_in3};
        endcase
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push_clear();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 9; c++)
                q.push_back('{row: 2'(r), col: 4'(c), data: 6'o40});
    endtask

    task automatic push_line(logic [1:0] row);
        for (int c = 0; c < 9; c++)
            q.push_back('{row: row, col: 4'(c), data: model_char(c)});
    endtask

    task automatic random_ops();
        {aSign, bSign, bothSign} = 3'($urandom_range(0, 7));
        x_in1 = 4'($urandom_range(0, 15));
        x_in2 = 4'($urandom_range(0, 15));
        x_in3 = 4'($urandom_range(0, 15));
        x_in4 = 4'($urandom_range(0, 15));
        Op    = 4'($urandom_range(0, 15));
    endtask

    task automatic pulse_enter();
        enter = 1'b1;
        repeat (2) @(negedge CLOCK_50);
        enter = 1'b0;
        repeat (2) @(negedge CLOCK_50);
    endtask

    task automatic wait_drain(string tag);
        int n = 0;
        while ((q.size() != 0 || busy) && n < 300) begin
            @(negedge CLOCK_50);
            n++;
        end
        check({tag, "_drained"}, 32'(n < 300), 32'd1);
        repeat (3) @(negedge CLOCK_50);
    endtask

    task automatic wait_col(logic [3:0] col);
        int n = 0;
        while (!(wr_en && wr_col == col) && n < 100) begin
            @(negedge CLOCK_50);
            n++;
        end
        check("wait_col_reached", 32'(n < 100), 32'd1);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge CLOCK_50);
        check("rst_wr_en", 32'(wr_en), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_cur_line", 32'(cur_line), 0);
        check("rst_wr_data", 32'(wr_data), 0);

        // 1: release triggers a full 36-write blanking sweep
        push_clear();
        ar = 1'b1;
        wait_drain("t1");
        check("t1_busy", 32'(busy), 0);
        check("t1_cur_line", 32'(cur_line), 0);

        // 2: fixed operands, latency and capture
        aSign = 1; x_in4 = 3; Op = 4'b0001; bSign = 0; x_in1 = 4;
        bothSign = 0; x_in2 = 0; x_in3 = 7;
        q.push_back('{2'd0, 4'd0, 6'o55}); q.push_back('{2'd0, 4'd1, 6'o63});
        q.push_back('{2'd0, 4'd2, 6'o53}); q.push_back('{2'd0, 4'd3, 6'o40});
        q.push_back('{2'd0, 4'd4, 6'o64}); q.push_back('{2'd0, 4'd5, 6'o75});
        q.push_back('{2'd0, 4'd6, 6'o40}); q.push_back('{2'd0, 4'd7, 6'o60});
        q.push_back('{2'd0, 4'd8, 6'o67});
        enter = 1'b1;
        @(negedge CLOCK_50);
        check("t2_lat_n1", 32'(wr_en), 0);
        @(negedge CLOCK_50);
        check("t2_lat_n2", 32'(wr_en), 0);
        @(negedge CLOCK_50);
        check("t2_first_wr_en", 32'(wr_en), 1);
        check("t2_first_col", 32'(wr_col), 0);
        enter = 1'b0;
        random_ops();
        repeat (9) @(negedge CLOCK_50);
        check("t2_done_pulse", 32'(done), 1);
        check("t2_done_wr_en", 32'(wr_en), 0);
        @(negedge CLOCK_50);
        check("t2_done_low", 32'(done), 0);
        check("t2_cur_line", 32'(cur_line), 1);
        done_exp++;
        wait_drain("t2");

        // 3: clear from IDLE, then five lines wrapping the row pointer
        push_clear();
        clear_req = 1'b1;
        @(negedge CLOCK_50);
        clear_req = 1'b0;
        wait_drain("t3_clear");
        check("t3_clear_cur_line", 32'(cur_line), 0);
        for (int i = 0; i < 5; i++) begin
            random_ops();
            push_line(2'(i));
            pulse_enter();
            wait_drain("t3_line");
            done_exp++;
        end
        check("t3_cur_line", 32'(cur_line), 1);

        // 4: second enter queued mid-write, third dropped
        random_ops();
        push_line(2'd1);
        pulse_enter();
        wait_col(4'd2);
        random_ops();
        push_line(2'd2);
        pulse_enter();
        pulse_enter();
        wait_drain("t4");
        repeat (10) @(negedge CLOCK_50);
        done_exp += 2;
        check("t4_cur_line", 32'(cur_line), 3);
        check("t4_done_count", 32'(done_cnt), 32'(done_exp));

        // 5: clear request during a write lets the line finish first
        random_ops();
        push_line(2'd3);
        pulse_enter();
        wait_col(4'd4);
        push_clear();
        clear_req = 1'b1;
        @(negedge CLOCK_50);
        clear_req = 1'b0;
        wait_drain("t5");
        done_exp++;
        check("t5_cur_line", 32'(cur_line), 0);
        check("t5_done_count", 32'(done_cnt), 32'(done_exp));

        // 6: async reset mid-write abandons the line and re-blanks
        random_ops();
        push_line(2'd0);
        pulse_enter();
        wait_col(4'd3);
        #2 ar = 1'b0;
        #1;
        check("t6_async_wr_en", 32'(wr_en), 0);
        check("t6_async_busy", 32'(busy), 0);
        check("t6_async_cur_line", 32'(cur_line), 0);
        q.delete();
        push_clear();
        @(negedge CLOCK_50);
        ar = 1'b1;
        wait_drain("t6");
        repeat (10) @(negedge CLOCK_50);
        check("t6_cur_line", 32'(cur_line), 0);
        check("t6_done_count", 32'(done_cnt), 32'(done_exp));
        check("t6_queue_empty", 32'(q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
